// File: rtl/multicycle_main_fsm.sv
// multicycle_main_fsm
//   Main control FSM for the multicycle ARM-subset core. It walks the
//   shared datapath through fetch / decode / execute. It also emits the
//   raw RegW / MemW / Branch strobes, which the conditional logic later
//   gates with the condition check.
//
// Ports
//   clk, reset        rising-edge clock, async active-high reset
//   Op[1:0]           instr[27:26]
//   Funct[5:0]        instr[25:20] (Funct[5]=I, Funct[0]=L)
//   MemReady          memory handshake (only with FSM_MEM_WAIT_EN)
//   IRWrite, AdrSrc, ALUSrcA, ALUSrcB[1:0], ALUOp, ResultSrc[1:0],
//   NextPC, RegW, MemW, Branch   datapath controls (Moore decode)
//   State[STATE_W-1:0]           current state code (debug)
//
// Build option
//   FSM_MEM_WAIT_EN   adds the MemReady input. With it, FETCH, MEMREAD
//                     and MEMWRITE stall until memory is ready.
module multicycle_main_fsm #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         Op,
  input  logic [5:0]         Funct,
`ifdef FSM_MEM_WAIT_EN
  input  logic               MemReady,
`endif
  output logic               IRWrite,
  output logic               AdrSrc,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic               ALUOp,
  output logic [1:0]         ResultSrc,
  output logic               NextPC,
  output logic               RegW,
  output logic               MemW,
  output logic               Branch,
  output logic [STATE_W-1:0] State
);

  typedef enum logic [STATE_W-1:0] {
    FETCH    = STATE_W'(0),
    DECODE   = STATE_W'(1),
    MEMADR   = STATE_W'(2),
    MEMREAD  = STATE_W'(3),
    MEMWB    = STATE_W'(4),
    MEMWRITE = STATE_W'(5),
    EXECUTER = STATE_W'(6),
    EXECUTEI = STATE_W'(7),
    ALUWB    = STATE_W'(8),
    BRANCH   = STATE_W'(9)
  } state_t;

  state_t state_q, state_d;
  logic   mem_rdy;

`ifdef FSM_MEM_WAIT_EN
  assign mem_rdy = MemReady;
`else
  assign mem_rdy = 1'b1;
`endif

  // Only I and L are decoded here; the middle Funct bits go to the ALU decoder.
  logic unused_funct;
  assign unused_funct = ^Funct[4:1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH:    state_d = mem_rdy ? DECODE : FETCH;
      DECODE: begin
        unique case (Op)
          2'b01:   state_d = MEMADR;
          2'b00:   state_d = Funct[5] ? EXECUTEI : EXECUTER;
          2'b10:   state_d = BRANCH;
          default: state_d = FETCH;   // undefined opcode: no-op
        endcase
      end
      MEMADR:   state_d = Funct[0] ? MEMREAD : MEMWRITE;
      MEMREAD:  state_d = mem_rdy ? MEMWB : MEMREAD;
      MEMWB:    state_d = FETCH;
      MEMWRITE: state_d = mem_rdy ? FETCH : MEMWRITE;
      EXECUTER: state_d = ALUWB;
      EXECUTEI: state_d = ALUWB;
      ALUWB:    state_d = FETCH;
      BRANCH:   state_d = FETCH;
      default:  state_d = FETCH;      // illegal codes recover to fetch
    endcase
  end

  always_comb begin
    IRWrite   = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ALUOp     = 1'b0;
    ResultSrc = 2'b00;
    NextPC    = 1'b0;
    RegW      = 1'b0;
    MemW      = 1'b0;
    Branch    = 1'b0;
    unique case (state_q)
      FETCH: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        // Qualified by mem_rdy so the PC moves once per fetch, even when stalled.
        IRWrite   = mem_rdy;
        NextPC    = mem_rdy;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      MEMADR:   ALUSrcB = 2'b01;
      MEMREAD:  AdrSrc  = 1'b1;
      MEMWB: begin
        ResultSrc = 2'b01;
        RegW      = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc = 1'b1;
        MemW   = 1'b1;   // held through wait cycles
      end
      EXECUTER: ALUOp = 1'b1;
      EXECUTEI: begin
        ALUSrcB = 2'b01;
        ALUOp   = 1'b1;
      end
      ALUWB:    RegW = 1'b1;
      BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        Branch    = 1'b1;
      end
      default: ;
    endcase
  end

  assign State = state_q;

endmodule

// File: tb/tb_multicycle_main_fsm.sv
module tb_multicycle_main_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] Op;
  logic [5:0] Funct;
`ifdef FSM_MEM_WAIT_EN
  logic       MemReady;
`endif
  logic       IRWrite, AdrSrc, ALUSrcA, ALUOp, NextPC, RegW, MemW, Branch;
  logic [1:0] ALUSrcB, ResultSrc;
  logic [3:0] State;

  multicycle_main_fsm #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct),
`ifdef FSM_MEM_WAIT_EN
    .MemReady(MemReady),
`endif
    .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .ResultSrc(ResultSrc), .NextPC(NextPC), .RegW(RegW),
    .MemW(MemW), .Branch(Branch), .State(State)
  );

  always #5 clk = ~clk;

  // {IRWrite,AdrSrc,ALUSrcA,ALUSrcB,ALUOp,ResultSrc,NextPC,RegW,MemW,Branch}
  logic [12:0] out_vec;
  assign out_vec = {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ALUOp, ResultSrc,
                    NextPC, RegW, MemW, Branch};

  logic [12:0] exp_out [0:9];
  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts in FETCH, walks seq[0..n-1] and leaves the FSM in the final state.
  // Op/Funct are scrambled once they should no longer matter.
  task automatic run(input string tag, input logic [1:0] op, input logic [5:0] fn,
                     input int seq [6], input int n,
                     input int exp_regw, input int exp_memw, input int exp_br);
    int c_regw = 0, c_memw = 0, c_br = 0, multi = 0;
    Op = op;
    Funct = fn;
    for (int i = 0; i < n; i++) begin
      if (i >= 2) Op = ~op;
      if (i >= 3) Funct = ~fn;
      chk($sformatf("%s st[%0d]", tag, i), {28'd0, State}, seq[i]);
      chk($sformatf("%s out[%0d]", tag, i), {19'd0, out_vec}, {19'd0, exp_out[seq[i]]});
      if (i < n - 1) begin
        c_regw += int'(RegW);
        c_memw += int'(MemW);
        c_br   += int'(Branch);
        if (int'(RegW) + int'(MemW) + int'(Branch) > 1) multi++;
        step();
      end
    end
    chk({tag, " regw_cnt"}, c_regw, exp_regw);
    chk({tag, " memw_cnt"}, c_memw, exp_memw);
    chk({tag, " br_cnt"}, c_br, exp_br);
    chk({tag, " strobe_overlap"}, multi, 0);
  endtask

  initial begin
    exp_out[0] = 13'b1_0_1_10_0_10_1_0_0_0;
    exp_out[1] = 13'b0_0_1_10_0_10_0_0_0_0;
    exp_out[2] = 13'b0_0_0_01_0_00_0_0_0_0;
    exp_out[3] = 13'b0_1_0_00_0_00_0_0_0_0;
    exp_out[4] = 13'b0_0_0_00_0_01_0_1_0_0;
    exp_out[5] = 13'b0_1_0_00_0_00_0_0_1_0;
    exp_out[6] = 13'b0_0_0_00_1_00_0_0_0_0;
    exp_out[7] = 13'b0_0_0_01_1_00_0_0_0_0;
    exp_out[8] = 13'b0_0_0_00_0_00_0_1_0_0;
    exp_out[9] = 13'b0_0_0_01_0_10_0_0_0_1;

    reset = 1'b1;
    Op = 2'b00;
    Funct = 6'd0;
`ifdef FSM_MEM_WAIT_EN
    MemReady = 1'b1;
`endif
    step();
    chk("rst state", {28'd0, State}, 0);
    chk("rst outs", {19'd0, out_vec}, {19'd0, exp_out[0]});
    reset = 1'b0;

    run("add_r", 2'b00, 6'b001000, '{0, 1, 6, 8, 0, 0}, 5, 1, 0, 0);
    run("add_i", 2'b00, 6'b101000, '{0, 1, 7, 8, 0, 0}, 5, 1, 0, 0);
    run("ldr",   2'b01, 6'b011001, '{0, 1, 2, 3, 4, 0}, 6, 1, 0, 0);
    run("str",   2'b01, 6'b011000, '{0, 1, 2, 5, 0, 0}, 5, 0, 1, 0);
    run("b",     2'b10, 6'b000000, '{0, 1, 9, 0, 0, 0}, 4, 0, 0, 1);
    run("op11",  2'b11, 6'b111111, '{0, 1, 0, 0, 0, 0}, 3, 0, 0, 0);

    // Reset asserted mid-LDR, between clock edges.
    Op = 2'b01;
    Funct = 6'b011001;
    step();
    step();
    step();
    chk("pre-rst memread", {28'd0, State}, 3);
    #2 reset = 1'b1;
    #1;
    chk("async rst state", {28'd0, State}, 0);
    chk("async rst irw", {31'd0, IRWrite}, 1);
    chk("async rst npc", {31'd0, NextPC}, 1);
    chk("async rst outs", {19'd0, out_vec}, {19'd0, exp_out[0]});
    step();
    chk("rst held state", {28'd0, State}, 0);
    reset = 1'b0;
    Op = 2'b11;
    step();
    chk("rst release decode", {28'd0, State}, 1);
    step();
    chk("op11 back to fetch", {28'd0, State}, 0);

`ifdef FSM_MEM_WAIT_EN
    MemReady = 1'b0;
    Op = 2'b10;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("wait st[%0d]", i), {28'd0, State}, 0);
      chk($sformatf("wait irw[%0d]", i), {31'd0, IRWrite}, 0);
      chk($sformatf("wait npc[%0d]", i), {31'd0, NextPC}, 0);
      step();
    end
    MemReady = 1'b1;
    chk("wait st[3]", {28'd0, State}, 0);
    chk("wait irw[3]", {31'd0, IRWrite}, 1);
    chk("wait npc[3]", {31'd0, NextPC}, 1);
    step();
    chk("wait decode", {28'd0, State}, 1);
    chk("wait decode irw", {31'd0, IRWrite}, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/multicycle_main_fsm.md
Name: multicycle_main_fsm

Overview:
- Main control state machine for the multicycle ARM-subset processor.
- Sequences the shared datapath (instruction/data memory port, ALU, register file write port) through fetch, decode, and execute steps.
- Generates the raw RegW/MemW/Branch strobes that the conditional-logic block gates with the condition check to produce the final architectural writes.
- Sits in the controller beside the ALU decoder and the conditional logic.

Parameters:
- STATE_W, 4, width of state register and State debug output; must be >= 4.

Ports:
- clk  input  1  system clock, rising-edge active
- reset  input  1  asynchronous, active-high reset
- Op  input  2  instruction bits [27:26]
- Funct  input  6  instruction bits [25:20]; Funct[5]=I (immediate), Funct[0]=L (load)
- IRWrite  output  1  load instruction register
- AdrSrc  output  1  memory address select: 0=PC, 1=ALU result
- ALUSrcA  output  1  0=register A, 1=PC
- ALUSrcB  output  2  00=register B, 01=ExtImm, 10=constant 4
- ALUOp  output  1  1=ALU decoder uses Funct; 0=force ADD
- ResultSrc  output  2  00=ALUOut, 01=read data, 10=ALU result
- NextPC  output  1  PC write strobe for sequential advance
- RegW  output  1  raw register write strobe
- MemW  output  1  raw memory write strobe
- Branch  output  1  raw branch strobe
- State  output  STATE_W  current state code, for debug

Behaviour:
- Moore machine: all outputs decode combinationally from the registered state only.
- Unlisted outputs are 0 in every state.
- State encoding, outputs per state, and next state:
  - 0 FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALUOp=0, ResultSrc=10, IRWrite=1, NextPC=1. Next: DECODE.
  - 1 DECODE: ALUSrcA=1, ALUSrcB=10, ALUOp=0, ResultSrc=10. Next by Op:
    - Op=01: MEMADR
    - Op=00, Funct[5]=0: EXECUTER
    - Op=00, Funct[5]=1: EXECUTEI
    - Op=10: BRANCH
    - Op=11: FETCH (undefined opcode, treated as no-op)
  - 2 MEMADR: ALUSrcA=0, ALUSrcB=01, ALUOp=0. Next: MEMREAD if Funct[0]=1, else MEMWRITE.
  - 3 MEMREAD: AdrSrc=1, ResultSrc=00. Next: MEMWB.
  - 4 MEMWB: ResultSrc=01, RegW=1. Next: FETCH.
  - 5 MEMWRITE: AdrSrc=1, ResultSrc=00, MemW=1. Next: FETCH.
  - 6 EXECUTER: ALUSrcA=0, ALUSrcB=00, ALUOp=1. Next: ALUWB.
  - 7 EXECUTEI: ALUSrcA=0, ALUSrcB=01, ALUOp=1. Next: ALUWB.
  - 8 ALUWB: ResultSrc=00, RegW=1. Next: FETCH.
  - 9 BRANCH: ALUSrcA=0, ALUSrcB=01, ALUOp=0, ResultSrc=10, Branch=1. Next: FETCH.
- Illegal codes 10-15: all outputs 0; next state FETCH.
- Op and Funct are sampled only in DECODE and MEMADR; they are ignored in all other states.
- Latency, counted from the FETCH cycle to the cycle after the last state:
  - B: 3 cycles
  - data-processing: 4 cycles
  - STR: 4 cycles
  - LDR: 5 cycles
- Reset:
  - Asserting reset forces the state to FETCH immediately, without waiting for a clock edge, from any state, including mid-instruction.
  - While reset is high, outputs are the FETCH values (IRWrite=1, NextPC=1, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, State=0).
  - On the first rising edge after reset deasserts, the state advances to DECODE.
- MemW, RegW, and Branch are each high for exactly one cycle per instruction. They are never high simultaneously.

Optional Feature:
- Macro: FSM_MEM_WAIT_EN.
- Defined:
  - Adds input port MemReady (1 bit), placed after Funct.
  - FETCH, MEMREAD, and MEMWRITE hold their state while MemReady=0.
  - In FETCH, IRWrite and NextPC are asserted only in the cycle where MemReady=1, so the PC advances exactly once per fetch.
  - MemW stays high for every MEMWRITE cycle, including wait cycles.
  - All other states ignore MemReady.
- Undefined:
  - No MemReady port.
  - Memory is single-cycle and the behaviour is exactly as above.

Test Plan:
- Reset:
  - reset=1 mid-MEMREAD -> State=0 in the same cycle; IRWrite=1 and NextPC=1.
  - Release reset -> State=1 after one edge.
- ADD register form (Op=00, Funct=6'b001000): State sequence 0,1,6,8,0.
  - ALUOp=1 only in state 6.
  - RegW=1 only in state 8.
  - ALUSrcB=00 in state 6.
- LDR (Op=01, Funct=6'b011001): State sequence 0,1,2,3,4,0.
  - AdrSrc=1 in state 3.
  - ResultSrc=01 and RegW=1 in state 4.
  - MemW=0 throughout.
- STR (Op=01, Funct=6'b011000): State sequence 0,1,2,5,0.
  - MemW=1 for exactly one cycle, in state 5.
- B (Op=10): State sequence 0,1,9,0.
  - Branch=1 with ALUSrcB=01.
- Op=11: State sequence 0,1,0.
  - No RegW, MemW, or Branch pulse.
- FSM_MEM_WAIT_EN defined, MemReady low for 3 cycles in FETCH:
  - State holds at 0 for 4 cycles.
  - IRWrite and NextPC pulse once, only in the cycle where MemReady=1.
